alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator side of the ALU interface (alu_opcode / alu_imm1 / alu_imm2 -> alu_result).
- Accepts RV32I register-register (0110011) and register-immediate (0010011) ALU instructions over a valid/ready handshake.
- Decodes each instruction, reads operands from an internal 32x32 register file, and drives the external combinational ALU.
- Captures alu_result and writes it back to rd. Sits between fetch/decode and the ALU in the execute stage.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  unit can accept an instruction.
- instr  input  32  RV32I instruction word.
- alu_opcode  output  8  ALU operation select.
- alu_imm1  output  XLEN  ALU operand 1 (rs1 value).
- alu_imm2  output  XLEN  ALU operand 2 (rs2 value or sign-extended immediate).
- alu_result  input  XLEN  ALU result (combinational from the outputs above).
- wb_valid  output  1  one-cycle writeback pulse.
- wb_rd  output  5  writeback destination register.
- wb_data  output  XLEN  writeback value.
- illegal  output  1  one-cycle pulse: instruction rejected.
- dbg_addr  input  5  debug register-file read address.
- dbg_data  output  XLEN  combinational register-file read data (x0 reads 0).

Behaviour:
- alu_opcode encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- Reset (rst_n low, async): state IDLE; instr_ready=0; all other outputs 0; register file cleared to 0.
- instr_ready rises on the first clk edge after reset release.
- FSM states: IDLE, EXEC, WB, ERR.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr, drop instr_ready, then:
  - legal instruction -> EXEC;
  - illegal instruction -> ERR.
- EXEC (1 cycle): alu_opcode / alu_imm1 / alu_imm2 are registered and stable for the whole cycle. At the end-of-cycle edge, sample alu_result into wb_data and the register file, then -> WB.
- WB (1 cycle): wb_valid=1, wb_rd=rd, wb_data=result. Then -> IDLE with instr_ready=1.
- ERR (1 cycle): illegal=1, no register write, ALU outputs hold previous values. Then -> IDLE.
- Latency: accept at edge N, ALU driven during cycle N+1, wb_valid high in cycle N+2. Throughput is one instruction per 3 cycles.
- wb_valid, illegal and instr_ready are never high together.
- Writes to rd=0 are discarded; wb_valid still pulses with wb_rd=0 and wb_data=alu_result.
- Operand 2 for I-type = instr[31:20] sign-extended to XLEN. Shift-immediates use instr[24:20] zero-extended.
- Legality rules:
  - R-type: funct7 must be 0000000, or 0100000 only for funct3 000 (SUB) or 101 (SRA).
  - I-type: funct3 001 requires imm[11:5]=0000000; funct3 101 requires 0000000 (SRLI) or 0100000 (SRAI). There is no SUBI; I-type funct3 000 is always ADDI.
  - Any other major opcode is illegal.
- Operands are read in the accept cycle, so a write-after-write in WB completes before the next accept. No hazards exist.
- Reset asserted mid-EXEC/WB: the write is aborted and outputs clear immediately.
- instr_valid dropping while instr_ready=0 has no effect.
- instr is ignored unless accepted.
- dbg_data reflects a WB write from the cycle after the WB-entry edge.

Optional Feature:
- Macro: ALU_ISSUE_DBG_WRITE_EN.
- When defined: adds ports dbg_we (input 1) and dbg_wdata (input XLEN).
  - dbg_we=1 writes dbg_wdata to dbg_addr at the clk edge, in any state.
  - A simultaneous WB write to the same register wins.
  - Writes to x0 are ignored.
- When undefined: no extra ports; the register file is written only by writeback.

Test Plan:
- Reset: rst_n low 3 cycles -> instr_ready=0, wb_valid=0, illegal=0, dbg_data=0 for all addresses; instr_ready=1 one edge after release.
- ADDI x1,x0,5 then ADDI x2,x0,-3 -> alu_opcode=0 and alu_imm2=0xFFFFFFFD in EXEC; wb pulses (rd1, 5) and (rd2, 0xFFFFFFFD) each 2 cycles after accept.
- SUB x3,x1,x2 with x1=5, x2=-3 -> alu_opcode=1, alu_imm1=5, alu_imm2=0xFFFFFFFD; wb_data=8, dbg_addr=3 reads 8.
- SRAI x4,x2,1 -> alu_opcode=7, alu_imm2=1; wb_data=0xFFFFFFFE. SLLI with imm[11:5]=0100000 -> illegal pulses once, no wb, x4 unchanged.
- ADD x0,x1,x1 -> wb_valid with wb_rd=0, wb_data=10; dbg_addr=0 still reads 0. Back-to-back instr_valid held high -> accepts exactly 3 cycles apart.
- Reset pulse in EXEC of ADDI x5,x0,7 -> no wb_valid, x5 reads 0, normal operation resumes after release.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// -----------------------------------------------------------------------------
// alu_issue_unit_if
// Purpose : Bundles the instruction handshake, ALU request/response,
//           writeback and debug read signals of the ALU issue unit.
// Optional: ALU_ISSUE_DBG_WRITE_EN adds dbg_we / dbg_wdata (debug write port).
// Modports:
//   master - the issue unit (accepts instructions, drives the ALU).
//   slave  - the environment (fetch/decode, external ALU, debug host).
// Signals:
//   instr_valid/instr_ready/instr    instruction handshake
//   alu_opcode/alu_imm1/alu_imm2     ALU request, alu_result ALU response
//   wb_valid/wb_rd/wb_data           writeback pulse
//   illegal                          rejected-instruction pulse
//   dbg_addr/dbg_data                register-file debug read
// -----------------------------------------------------------------------------
interface alu_issue_unit_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [7:0]      alu_opcode;
    logic [XLEN-1:0] alu_imm1;
    logic [XLEN-1:0] alu_imm2;
    logic [XLEN-1:0] alu_result;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;
`ifdef ALU_ISSUE_DBG_WRITE_EN
    logic            dbg_we;
    logic [XLEN-1:0] dbg_wdata;
`endif

    modport master (
        input  instr_valid, instr, alu_result, dbg_addr,
`ifdef ALU_ISSUE_DBG_WRITE_EN
        input  dbg_we, dbg_wdata,
`endif
        output instr_ready, alu_opcode, alu_imm1, alu_imm2,
        output wb_valid, wb_rd, wb_data, illegal, dbg_data
    );

    modport slave (
        output instr_valid, instr, alu_result, dbg_addr,
`ifdef ALU_ISSUE_DBG_WRITE_EN
        output dbg_we, dbg_wdata,
`endif
        input  instr_ready, alu_opcode, alu_imm1, alu_imm2,
        input  wb_valid, wb_rd, wb_data, illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
// Purpose : Execute-stage issue unit for RV32I OP (0110011) and OP-IMM
//           (0010011) instructions. Decodes the instruction, reads operands
//           from an internal 32x32 register file, drives an external
//           combinational ALU for one cycle and writes the result back.
//           One instruction every 3 cycles: IDLE -> EXEC -> WB (or IDLE -> ERR).
// Optional: define ALU_ISSUE_DBG_WRITE_EN to add a debug register-file write
//           port (dbg_we / dbg_wdata); writeback wins on a same-register clash.
// Ports   :
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_issue_unit_if.master (handshake, ALU, writeback, debug)
// -----------------------------------------------------------------------------
module alu_issue_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_unit_if.master    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_SUB  = 8'd1;
    localparam logic [7:0] OP_SLL  = 8'd2;
    localparam logic [7:0] OP_SLT  = 8'd3;
    localparam logic [7:0] OP_SLTU = 8'd4;
    localparam logic [7:0] OP_XOR  = 8'd5;
    localparam logic [7:0] OP_SRL  = 8'd6;
    localparam logic [7:0] OP_SRA  = 8'd7;
    localparam logic [7:0] OP_OR   = 8'd8;
    localparam logic [7:0] OP_AND  = 8'd9;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_instr_ready;
    logic [7:0]      r_alu_opcode;
    logic [XLEN-1:0] r_alu_imm1;
    logic [XLEN-1:0] r_alu_imm2;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_illegal;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rf [NREGS];

    logic [6:0]      w_major;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_f7_zero;
    logic            w_f7_alt;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm_sext;
    logic [XLEN-1:0] w_shamt;
    logic            w_legal;
    logic [7:0]      w_opcode;
    logic [XLEN-1:0] w_op2;
    logic            w_accept;

    assign w_major    = bus.instr[6:0];
    assign w_rd       = bus.instr[11:7];
    assign w_funct3   = bus.instr[14:12];
    assign w_rs1      = bus.instr[19:15];
    assign w_rs2      = bus.instr[24:20];
    assign w_funct7   = bus.instr[31:25];
    assign w_f7_zero  = (w_funct7 == 7'b0000000);
    assign w_f7_alt   = (w_funct7 == 7'b0100000);
    assign w_imm_sext = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign w_shamt    = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

    // x0 is never written, but the read is forced to zero regardless
    assign w_rs1_val  = (w_rs1 == 5'd0) ? {XLEN{1'b0}} : r_rf[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? {XLEN{1'b0}} : r_rf[w_rs2];
    assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? {XLEN{1'b0}} : r_rf[bus.dbg_addr];

    assign w_accept = (r_state == S_IDLE) && r_instr_ready && bus.instr_valid;

    assign bus.instr_ready = r_instr_ready;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_imm1    = r_alu_imm1;
    assign bus.alu_imm2    = r_alu_imm2;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.illegal     = r_illegal;

    // Instruction decode: legality, ALU operation and operand 2 selection
    always_comb begin
        w_legal  = 1'b0;
        w_opcode = OP_ADD;
        w_op2    = w_rs2_val;
        case (w_major)
            7'b0110011: begin
                w_op2 = w_rs2_val;
                case (w_funct3)
                    3'b000: begin
                        w_opcode = w_f7_alt ? OP_SUB : OP_ADD;
                        w_legal  = w_f7_zero | w_f7_alt;
                    end
                    3'b001: begin w_opcode = OP_SLL;  w_legal = w_f7_zero; end
                    3'b010: begin w_opcode = OP_SLT;  w_legal = w_f7_zero; end
                    3'b011: begin w_opcode = OP_SLTU; w_legal = w_f7_zero; end
                    3'b100: begin w_opcode = OP_XOR;  w_legal = w_f7_zero; end
                    3'b101: begin
                        w_opcode = w_f7_alt ? OP_SRA : OP_SRL;
                        w_legal  = w_f7_zero | w_f7_alt;
                    end
                    3'b110: begin w_opcode = OP_OR;   w_legal = w_f7_zero; end
                    3'b111: begin w_opcode = OP_AND;  w_legal = w_f7_zero; end
                    default: begin w_opcode = OP_ADD; w_legal = 1'b0; end
                endcase
            end
            7'b0010011: begin
                w_op2 = w_imm_sext;
                case (w_funct3)
                    // funct7 bits are immediate bits here, so ADDI has no SUB form
                    3'b000: begin w_opcode = OP_ADD;  w_legal = 1'b1; end
                    3'b001: begin
                        w_opcode = OP_SLL;
                        w_op2    = w_shamt;
                        w_legal  = w_f7_zero;
                    end
                    3'b010: begin w_opcode = OP_SLT;  w_legal = 1'b1; end
                    3'b011: begin w_opcode = OP_SLTU; w_legal = 1'b1; end
                    3'b100: begin w_opcode = OP_XOR;  w_legal = 1'b1; end
                    3'b101: begin
                        w_opcode = w_f7_alt ? OP_SRA : OP_SRL;
                        w_op2    = w_shamt;
                        w_legal  = w_f7_zero | w_f7_alt;
                    end
                    3'b110: begin w_opcode = OP_OR;   w_legal = 1'b1; end
                    3'b111: begin w_opcode = OP_AND;  w_legal = 1'b1; end
                    default: begin w_opcode = OP_ADD; w_legal = 1'b0; end
                endcase
            end
            default: begin
                w_legal  = 1'b0;
                w_opcode = OP_ADD;
                w_op2    = w_rs2_val;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_legal ? S_EXEC : S_ERR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and registered outputs; the flags are decoded from the
    // next state so each is high for exactly the cycle its state occupies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_instr_ready <= 1'b0;
            r_alu_opcode  <= 8'd0;
            r_alu_imm1    <= {XLEN{1'b0}};
            r_alu_imm2    <= {XLEN{1'b0}};
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= 5'd0;
            r_wb_data     <= {XLEN{1'b0}};
            r_illegal     <= 1'b0;
            r_rd          <= 5'd0;
        end else begin
            r_state       <= w_next_state;
            r_instr_ready <= (w_next_state == S_IDLE);
            r_wb_valid    <= (w_next_state == S_WB);
            r_illegal     <= (w_next_state == S_ERR);
            // Illegal instructions leave the ALU request untouched
            if (w_accept && w_legal) begin
                r_alu_opcode <= w_opcode;
                r_alu_imm1   <= w_rs1_val;
                r_alu_imm2   <= w_op2;
                r_rd         <= w_rd;
            end
            if (r_state == S_EXEC) begin
                r_wb_data <= bus.alu_result;
                r_wb_rd   <= r_rd;
            end
        end
    end

    // Register file: cleared on reset, written at the EXEC->WB edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= {XLEN{1'b0}};
            end
        end else begin
`ifdef ALU_ISSUE_DBG_WRITE_EN
            if (bus.dbg_we && (bus.dbg_addr != 5'd0)) begin
                r_rf[bus.dbg_addr] <= bus.dbg_wdata;
            end
`endif
            // Placed last so a same-register writeback overrides a debug write
            if ((r_state == S_EXEC) && (r_rd != 5'd0)) begin
                r_rf[r_rd] <= bus.alu_result;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
// Purpose : Directed self-checking bench for alu_issue_unit. Models the
//           external combinational ALU, issues hand-encoded RV32I
//           instructions and compares every output against hand-computed
//           values. Ends with a single TB_RESULT summary line.
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_issue_unit_if #(.XLEN(32)) bus ();

    alu_issue_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU model
    always_comb begin
        case (bus.alu_opcode)
            8'd0:    bus.alu_result = bus.alu_imm1 + bus.alu_imm2;
            8'd1:    bus.alu_result = bus.alu_imm1 - bus.alu_imm2;
            8'd2:    bus.alu_result = bus.alu_imm1 << bus.alu_imm2[4:0];
            8'd3:    bus.alu_result = {31'd0, $signed(bus.alu_imm1) < $signed(bus.alu_imm2)};
            8'd4:    bus.alu_result = {31'd0, bus.alu_imm1 < bus.alu_imm2};
            8'd5:    bus.alu_result = bus.alu_imm1 ^ bus.alu_imm2;
            8'd6:    bus.alu_result = bus.alu_imm1 >> bus.alu_imm2[4:0];
            8'd7:    bus.alu_result = $unsigned($signed(bus.alu_imm1) >>> bus.alu_imm2[4:0]);
            8'd8:    bus.alu_result = bus.alu_imm1 | bus.alu_imm2;
            8'd9:    bus.alu_result = bus.alu_imm1 & bus.alu_imm2;
            default: bus.alu_result = 32'd0;
        endcase
    end

    // Single comparison point: counts and reports mismatches
    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Offer one instruction and check EXEC/WB (legal) or ERR (illegal) cycles.
    // For illegal instructions eop/ei1/ei2 are the held ALU outputs.
    task automatic issue(input string tag, input logic [31:0] ins, input bit legal,
                         input logic [7:0] eop, input logic [31:0] ei1, input logic [31:0] ei2,
                         input logic [4:0] erd, input logic [31:0] edata);
        int budget;
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        budget = 0;
        while (!bus.instr_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.instr_ready) begin
            chk_val({tag, "_ready_timeout"}, {31'd0, bus.instr_ready}, 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_val({tag, "_op"},  {24'd0, bus.alu_opcode}, {24'd0, eop});
        chk_val({tag, "_i1"},  bus.alu_imm1, ei1);
        chk_val({tag, "_i2"},  bus.alu_imm2, ei2);
        chk_val({tag, "_rdy1"}, {31'd0, bus.instr_ready}, 32'd0);
        chk_val({tag, "_wbv1"}, {31'd0, bus.wb_valid}, 32'd0);
        if (legal) begin
            chk_val({tag, "_ill1"}, {31'd0, bus.illegal}, 32'd0);
            @(negedge clk);
            chk_val({tag, "_wbv2"}, {31'd0, bus.wb_valid}, 32'd1);
            chk_val({tag, "_wbrd"}, {27'd0, bus.wb_rd}, {27'd0, erd});
            chk_val({tag, "_wbd"},  bus.wb_data, edata);
            chk_val({tag, "_ill2"}, {31'd0, bus.illegal}, 32'd0);
            chk_val({tag, "_rdy2"}, {31'd0, bus.instr_ready}, 32'd0);
        end else begin
            chk_val({tag, "_ill1"}, {31'd0, bus.illegal}, 32'd1);
        end
        @(negedge clk);
        chk_val({tag, "_rdy_end"}, {31'd0, bus.instr_ready}, 32'd1);
        chk_val({tag, "_wbv_end"}, {31'd0, bus.wb_valid}, 32'd0);
        chk_val({tag, "_ill_end"}, {31'd0, bus.illegal}, 32'd0);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.dbg_addr = addr;
        #1;
        chk_val(tag, bus.dbg_data, exp);
    endtask

    initial begin
        int accepts[$];
        int overlap;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.dbg_addr    = 5'd0;
`ifdef ALU_ISSUE_DBG_WRITE_EN
        bus.dbg_we      = 1'b0;
        bus.dbg_wdata   = 32'd0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk_val("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk_val("rst_wbv",   {31'd0, bus.wb_valid}, 32'd0);
        chk_val("rst_ill",   {31'd0, bus.illegal}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            chk_reg("rst_rf", a[4:0], 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk_val("rel_ready0", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clk);
        chk_val("rel_ready1", {31'd0, bus.instr_ready}, 32'd1);

        // ADDI x1,x0,5 / ADDI x2,x0,-3
        issue("addi1", enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1'b1, 8'd0, 32'd0, 32'd5, 5'd1, 32'd5);
        issue("addi2", enc_i(12'hFFD, 5'd0, 3'b000, 5'd2), 1'b1, 8'd0, 32'd0, 32'hFFFF_FFFD,
              5'd2, 32'hFFFF_FFFD);
        chk_reg("x1", 5'd1, 32'd5);
        chk_reg("x2", 5'd2, 32'hFFFF_FFFD);

        // SUB x3,x1,x2 -> 5 - (-3) = 8
        issue("sub", enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 8'd1, 32'd5,
              32'hFFFF_FFFD, 5'd3, 32'd8);
        chk_reg("x3", 5'd3, 32'd8);

        // SRAI x4,x2,1 -> -3 >>> 1 = -2
        issue("srai", enc_i(12'h401, 5'd2, 3'b101, 5'd4), 1'b1, 8'd7, 32'hFFFF_FFFD, 32'd1,
              5'd4, 32'hFFFF_FFFE);
        chk_reg("x4", 5'd4, 32'hFFFF_FFFE);

        // SLLI with imm[11:5]=0100000 is illegal; ALU outputs hold SRAI values
        issue("slli_bad", enc_i(12'h401, 5'd1, 3'b001, 5'd4), 1'b0, 8'd7, 32'hFFFF_FFFD,
              32'd1, 5'd0, 32'd0);
        chk_reg("x4_kept", 5'd4, 32'hFFFF_FFFE);

        // ADD x0,x1,x1 -> pulse with rd 0 and data 10, x0 stays zero
        issue("add_x0", enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd0), 1'b1, 8'd0, 32'd5, 32'd5,
              5'd0, 32'd10);
        chk_reg("x0", 5'd0, 32'd0);

        // Unsupported major opcode (LOAD) and R-type AND with funct7=0100000
        issue("load_bad", 32'h0000_2083, 1'b0, 8'd0, 32'd5, 32'd5, 5'd0, 32'd0);
        issue("and_bad", enc_r(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd7), 1'b0, 8'd0, 32'd5, 32'd5,
              5'd0, 32'd0);
        chk_reg("x7", 5'd7, 32'd0);

        // Back-to-back: instr_valid held high, ADDI x6,x0,1 repeatedly
        @(negedge clk);
        bus.instr       = enc_i(12'd1, 5'd0, 3'b000, 5'd6);
        bus.instr_valid = 1'b1;
        overlap = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.instr_ready) accepts.push_back(c);
            if ((bus.instr_ready && bus.wb_valid) || (bus.instr_ready && bus.illegal) ||
                (bus.wb_valid && bus.illegal)) overlap++;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        chk_val("b2b_count", accepts.size(), 32'd4);
        if (accepts.size() >= 3) begin
            chk_val("b2b_gap1", accepts[1] - accepts[0], 32'd3);
            chk_val("b2b_gap2", accepts[2] - accepts[1], 32'd3);
        end else begin
            chk_val("b2b_short", accepts.size(), 32'd4);
        end
        chk_val("b2b_overlap", overlap, 32'd0);
        chk_reg("x6", 5'd6, 32'd1);

        // Reset pulse during EXEC of ADDI x5,x0,7
        @(negedge clk);
        bus.instr       = enc_i(12'd7, 5'd0, 3'b000, 5'd5);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk_val("rexec_i2", bus.alu_imm2, 32'd7);
        rst_n = 1'b0;
        #1;
        chk_val("rexec_i2_clr", bus.alu_imm2, 32'd0);
        chk_val("rexec_ready",  {31'd0, bus.instr_ready}, 32'd0);
        chk_reg("rexec_x5", 5'd5, 32'd0);
        chk_reg("rexec_x1", 5'd1, 32'd0);
        @(negedge clk);
        chk_val("rexec_wbv", {31'd0, bus.wb_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("rexec_ready1", {31'd0, bus.instr_ready}, 32'd1);
        chk_reg("rexec_x5_after", 5'd5, 32'd0);
        issue("addi5", enc_i(12'd7, 5'd0, 3'b000, 5'd5), 1'b1, 8'd0, 32'd0, 32'd7, 5'd5, 32'd7);
        chk_reg("x5", 5'd5, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
